// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: opcode encoding and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SRA = 4'd7
  } op_t;

  // Any opcode with this bit set is illegal.
  localparam int OP_ILLEGAL_MSB = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return op[OP_ILLEGAL_MSB];
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command, ALU and response signals of the sequencer.
// Handshake rule for both channels: a transfer happens on a posedge where
// valid && ready are both 1; the sender holds valid and payload stable until
// that edge, and ready may depend combinationally on the other side's signals.
interface alu_seq_if #(
  parameter int N  = 8,
  parameter int TW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [N-1:0]  cmd_a;
  logic [N-1:0]  cmd_b;
  logic [TW-1:0] cmd_tag;

  logic [3:0]    alu_op;
  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [N-1:0]  alu_y;
  logic          alu_flg;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_y;
  logic          rsp_flg;
  logic          rsp_err;
  logic [TW-1:0] rsp_tag;

  // Parent side: issues commands, hosts the ALU, consumes responses.
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready, alu_y, alu_flg,
    input  cmd_ready, rsp_valid, rsp_y, rsp_flg, rsp_err, rsp_tag,
           alu_op, alu_a, alu_b
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready, alu_y, alu_flg,
    output cmd_ready, rsp_valid, rsp_y, rsp_flg, rsp_err, rsp_tag,
           alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_seq.sv
// ALU command sequencer: registers a command onto the ALU inputs, captures the
// result one cycle later and returns it with its tag on the response channel.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N  = 8,
  parameter int TW = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_seq_if.slave    bus,
  output logic        busy,
  output logic [15:0] cmd_count,
  output logic [7:0]  err_count,
  output state_t      dbg_state
);

  state_t        state;
  state_t        state_n;
  logic          accept;
  logic          cap_err;
  logic [N-1:0]  cap_y;
  logic [TW-1:0] tag_q;

  // Ready only when idle or when the pending response leaves this cycle.
  assign bus.cmd_ready = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.rsp_valid = (state == RESP);
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

  // Illegal opcodes report a zeroed result.
  assign cap_err = is_illegal(bus.alu_op);
  assign cap_y   = cap_err ? '0 : bus.alu_y;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = EXEC;
      EXEC:    state_n = RESP;
      RESP:    if (bus.rsp_ready) state_n = accept ? EXEC : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Command latch onto ALU inputs, result capture and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_op  <= '0;
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
      tag_q       <= '0;
      bus.rsp_y   <= '0;
      bus.rsp_flg <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.rsp_tag <= '0;
      cmd_count   <= '0;
      err_count   <= '0;
    end else begin
      if (accept) begin
        bus.alu_op <= bus.cmd_op;
        bus.alu_a  <= bus.cmd_a;
        bus.alu_b  <= bus.cmd_b;
        tag_q      <= bus.cmd_tag;
        cmd_count  <= cmd_count + 16'd1;
      end
      if (state == EXEC) begin
        bus.rsp_y   <= cap_y;
        bus.rsp_flg <= cap_err ? 1'b0 : bus.alu_flg;
        bus.rsp_err <= cap_err;
        bus.rsp_tag <= tag_q;
        if (cap_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq with a stand-in ALU beside it and a reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int N  = 8;
  localparam int TW = 4;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [15:0] cmd_count;
  logic [7:0]  err_count;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  // expected response: {err, flg, y, tag}
  logic [N+TW+1:0] exp_q[$];
  logic [15:0] m_cmd;
  logic [7:0]  m_err;

  alu_seq_if #(.N(N), .TW(TW)) bus ();

  alu_seq #(.N(N), .TW(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy),
    .cmd_count(cmd_count), .err_count(err_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stand-in ALU in the parent: combinational from alu_*
  always_comb begin
    bus.alu_y = 8'hA5;
    case (bus.alu_op)
      4'd0: bus.alu_y = bus.alu_a + bus.alu_b;
      4'd1: bus.alu_y = bus.alu_a - bus.alu_b;
      4'd2: bus.alu_y = bus.alu_a & bus.alu_b;
      4'd3: bus.alu_y = bus.alu_a | bus.alu_b;
      4'd4: bus.alu_y = bus.alu_a ^ bus.alu_b;
      4'd5: bus.alu_y = bus.alu_a << bus.alu_b[2:0];
      4'd6: bus.alu_y = bus.alu_a >> bus.alu_b[2:0];
      4'd7: bus.alu_y = 8'($signed(bus.alu_a) >>> bus.alu_b[2:0]);
      default: bus.alu_y = 8'hA5;
    endcase
    bus.alu_flg = bus.alu_op[3] ? 1'b1 : (bus.alu_y == 8'h00);
  end

  // reference: result of one command, from the opcode table
  function automatic logic [N+TW+1:0] ref_rsp(input int op, input int a, input int b,
                                              input int tag);
    int y;
    int sh;
    sh = b % 8;
    case (op)
      0: y = (a + b) % 256;
      1: y = (a - b + 256) % 256;
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = (a * (1 << sh)) % 256;
      6: y = a / (1 << sh);
      7: y = (a >= 128) ? ((a - 256) >>> sh) + 256 : a / (1 << sh);
      default: y = 0;
    endcase
    y = y % 256;
    if (op >= 8) return {1'b1, 1'b0, 8'h00, 4'(tag)};
    return {1'b0, (y == 0), 8'(y), 4'(tag)};
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive a command while idle; it is accepted at the next edge
  task automatic issue(input int op, input int a, input int b, input int tag);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'(op);
    bus.cmd_a     = 8'(a);
    bus.cmd_b     = 8'(b);
    bus.cmd_tag   = 4'(tag);
    #1;
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    exp_q.push_back(ref_rsp(op, a, b, tag));
    m_cmd = m_cmd + 16'd1;
    if (op >= 8 && m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  // one edge after accept: still executing; next edge: response valid
  task automatic check_rsp(input bit full);
    logic [N+TW+1:0] e;
    if (full) check("rsp_valid_exec", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("rsp_valid_resp", 32'(bus.rsp_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      if (full) begin
        check("rsp_tag", 32'(bus.rsp_tag), 32'(e[3:0]));
        check("rsp_flg", 32'(bus.rsp_flg), 32'(e[12]));
        check("rsp_err", 32'(bus.rsp_err), 32'(e[13]));
      end
      check("rsp_y", {bus.rsp_err, bus.rsp_flg, bus.rsp_y, bus.rsp_tag}, 32'(e));
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [N+TW+1:0] held;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_tag = '0;
    bus.rsp_ready = 1'b0;
    m_cmd = '0;
    m_err = '0;

    // 1. reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, 32'd0);
    check("rst_rsp", {bus.rsp_err, bus.rsp_flg, bus.rsp_y, bus.rsp_tag}, 32'd0);
    check("rst_counts", {cmd_count, err_count}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // 2. add
    issue(0, 8'h05, 8'h03, 2);
    check("alu_latched", {bus.alu_op, bus.alu_a, bus.alu_b}, {16'd0, 4'd0, 8'h05, 8'h03});
    check("busy_exec", 32'(busy), 32'd1);
    check("cmd_ready_exec", 32'(bus.cmd_ready), 32'd0);
    check_rsp(1);
    check("add_y", 32'(bus.rsp_y), 32'h08);
    consume();
    check("idle_after", 32'(busy), 32'd0);
    check("alu_hold", {bus.alu_op, bus.alu_a, bus.alu_b}, {16'd0, 4'd0, 8'h05, 8'h03});

    // 3. sub to zero, arithmetic shift
    issue(1, 8'h2A, 8'h2A, 3);
    check_rsp(1);
    check("sub_zero_flg", {bus.rsp_y, 7'd0, bus.rsp_flg}, {8'h00, 7'd0, 1'b1});
    consume();
    issue(7, 8'h80, 8'h01, 4);
    check_rsp(1);
    check("sra_y", 32'(bus.rsp_y), 32'hC0);
    consume();

    // 4. illegal opcodes and saturation
    issue(9, 8'h12, 8'h34, 1);
    check_rsp(1);
    check("illegal_err", {bus.rsp_err, bus.rsp_y}, {1'b1, 8'h00});
    check("err_count_1", 32'(err_count), 32'd1);
    consume();
    for (int i = 0; i < 300; i++) begin
      issue(15, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), i % 16);
      check_rsp(0);
      consume();
    end
    check("err_count_sat", 32'(err_count), 32'(m_err));
    check("err_count_ff", 32'(err_count), 32'hFF);
    check("cmd_count_304", 32'(cmd_count), 32'(m_cmd));

    // 5. backpressure, then back-to-back accept
    issue(4, 8'hAA, 8'h0F, 5);
    check_rsp(1);
    held = {bus.rsp_err, bus.rsp_flg, bus.rsp_y, bus.rsp_tag};
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 4'd2;
    bus.cmd_a = 8'hF0;
    bus.cmd_b = 8'h3C;
    bus.cmd_tag = 4'd6;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_stable", {bus.rsp_err, bus.rsp_flg, bus.rsp_y, bus.rsp_tag}, 32'(held));
      check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    check("stall_no_accept", 32'(cmd_count), 32'(m_cmd));
    bus.rsp_ready = 1'b1;
    #1;
    check("b2b_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    exp_q.push_back(ref_rsp(2, 8'hF0, 8'h3C, 6));
    m_cmd = m_cmd + 16'd1;
    check("b2b_accepted", 32'(cmd_count), 32'(m_cmd));
    check_rsp(1);
    check("b2b_and_y", 32'(bus.rsp_y), 32'h30);
    consume();

    // random commands with random backpressure
    for (int i = 0; i < 40; i++) begin
      int st;
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
      check_rsp(1);
      held = {bus.rsp_err, bus.rsp_flg, bus.rsp_y, bus.rsp_tag};
      st = int'($urandom_range(0, 3));
      for (int j = 0; j < st; j++) tick();
      check("rand_hold", {bus.rsp_err, bus.rsp_flg, bus.rsp_y, bus.rsp_tag}, 32'(held));
      consume();
    end
    check("rand_cmd_count", 32'(cmd_count), 32'(m_cmd));
    check("rand_err_count", 32'(err_count), 32'(m_err));

    // 6. reset during EXEC
    issue(0, 8'h11, 8'h22, 7);
    check("pre_rst_state", 32'(dbg_state), 32'(EXEC));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("rst_exec_state", 32'(dbg_state), 32'(IDLE));
    check("rst_exec_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_exec_counts", {cmd_count, err_count}, 32'd0);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);
    end
    bus.rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
